muldiv_unit: RTL

- Parametrised, multi-cycle RV32M/RV64M multiply/divide unit. Sits beside the single-cycle ALU in the execute stage.
- Computes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU one bit per cycle.
- Uses a start/done handshake so the pipelined core can stall on busy and kill an operation on flush.

---
 rtl/muldiv_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Latency: XLEN+2 cycles from accept to done (MULDIV_EARLY_OUT_EN: trivial cases finish in 1 cycle).
// Backpressure: ready only in IDLE, start ignored otherwise; flush aborts without done, result held.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            ready,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   localparam logic [XLEN-1:0]   ONE   = XLEN'(1);
   localparam logic [2*XLEN-1:0] PONE  = (2*XLEN)'(1);
   localparam logic [XLEN-1:0]   S_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic [XLEN-1:0] mb_q, mb_d;        // |b|: multiplicand or divisor
   logic [XLEN-1:0] acc_q, acc_d;      // product high half / partial remainder
   logic [XLEN-1:0] lo_q, lo_d;        // multiplier -> product low half / dividend -> quotient
   logic            neg_q, neg_d;      // negate the selected result in FIX
   logic            spec_q, spec_d;    // special case pending
   logic [XLEN-1:0] spec_val_q, spec_val_d;
   logic [XLEN-1:0] result_q, result_d;

   // Operand decode on accept: magnitudes, result sign and special cases
   logic            signed_a, signed_b, a_neg, b_neg, res_neg, div0, ovf, spec_hit;
   logic [XLEN-1:0] a_mag, b_mag, spec_val;
`ifdef MULDIV_EARLY_OUT_EN
   logic            early;
`endif

   always_comb begin
      signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      a_neg    = signed_a & a[XLEN-1];
      b_neg    = signed_b & b[XLEN-1];
      a_mag    = a_neg ? (~a + ONE) : a;
      b_mag    = b_neg ? (~b + ONE) : b;
      // REM follows the dividend sign; everything else follows sign(a) ^ sign(b)
      res_neg  = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
      div0     = op[2] && (b == '0);
      ovf      = ((op == OP_DIV) || (op == OP_REM)) && (a == S_MIN) && (b == '1);
      spec_hit = 1'b0;
      spec_val = '0;
      if (div0) begin
         spec_hit = 1'b1;
         spec_val = op[1] ? a : '1;
      end else if (ovf) begin
         spec_hit = 1'b1;
         spec_val = op[1] ? '0 : a;
      end
`ifdef MULDIV_EARLY_OUT_EN
      // a zero operand yields zero for every op once divide-by-zero is excluded
      early = spec_hit || (a == '0) || (b == '0);
`endif
   end

   // One iteration of shift-add multiply and restoring divide
   logic [XLEN:0]   mul_sum, div_shift;
   logic [XLEN-1:0] div_diff;
   logic            div_ge;

   always_comb begin
      mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mb_q} : {(XLEN+1){1'b0}});
      div_shift = {acc_q, lo_q[XLEN-1]};
      div_ge    = div_shift >= {1'b0, mb_q};
      div_diff  = div_shift[XLEN-1:0] - mb_q;
   end

   // Sign correction and result selection for FIX
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

   always_comb begin
      prod     = {acc_q, lo_q};
      prod_fix = neg_q ? (~prod + PONE) : prod;
      quo_fix  = neg_q ? (~lo_q + ONE) : lo_q;
      rem_fix  = neg_q ? (~acc_q + ONE) : acc_q;
      if (spec_q)
         fix_val = spec_val_q;
      else if (!op_q[2])
         fix_val = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      else
         fix_val = op_q[1] ? rem_fix : quo_fix;
   end

   // Next-state and datapath update; flush wins over every forward transition
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      mb_d       = mb_q;
      acc_d      = acc_q;
      lo_d       = lo_q;
      neg_d      = neg_q;
      spec_d     = spec_q;
      spec_val_d = spec_val_q;
      result_d   = result_q;
      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               op_d       = op;
               mb_d       = b_mag;
               acc_d      = '0;
               lo_d       = a_mag;
               neg_d      = res_neg;
               spec_d     = spec_hit;
               spec_val_d = spec_val;
               cnt_d      = CNT_W'(XLEN-1);
               state_d    = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
               if (early) begin
                  result_d = spec_val;
                  state_d  = S_DONE;
               end
`endif
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               if (!op_q[2]) begin
                  acc_d = mul_sum[XLEN:1];
                  lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
               end else begin
                  acc_d = div_ge ? div_diff : div_shift[XLEN-1:0];
                  lo_d  = {lo_q[XLEN-2:0], div_ge};
               end
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == '0)
                  state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               result_d = fix_val;
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, cleared by asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         mb_q       <= '0;
         acc_q      <= '0;
         lo_q       <= '0;
         neg_q      <= 1'b0;
         spec_q     <= 1'b0;
         spec_val_q <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         mb_q       <= mb_d;
         acc_q      <= acc_d;
         lo_q       <= lo_d;
         neg_q      <= neg_d;
         spec_q     <= spec_d;
         spec_val_q <= spec_val_d;
         result_q   <= result_d;
      end
   end

   assign ready  = (state_q == S_IDLE);
   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE) && !flush;
   assign result = result_q;

endmodule
